sram_arbiter: RTL
=================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter NCH, 2, number of requester channels; legal 2..4.
REQ-002 Parameter AW, 20, SRAM address width.
REQ-003 Parameter DW, 48, SRAM data width; multiple of 16; NL = DW/16 lanes, lane k = bits [16k +: 16].
REQ-004 Parameter INIT_BASE, 20'h80000, first address of post-reset fill.
REQ-005 Parameter INIT_LEN, 128, words filled after reset; 0 = no fill.
REQ-006 Parameter INIT_WORD, 48'h000008080000, fill value.
REQ-007 clk_50mhz  in  1  sole clock, all state on rising edge.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 ch_stb  in  NCH  per-channel request, held until its ack.
REQ-010 ch_we  in  NCH  1 = write, 0 = read.
REQ-011 ch_addr  in  NCH*AW  channel i at [i*AW +: AW].
REQ-012 ch_din  in  NCH*DW  write data, channel i at [i*DW +: DW].
REQ-013 ch_lane  in  NCH*NL  per-lane write enables.
REQ-014 ch_dout  out  NCH*DW  read data, valid in ack cycle, held until next read ack on that channel.
REQ-015 ch_ack  out  NCH  one-cycle completion pulse.
REQ-016 scan_req  in  1  display fetch request, level.
REQ-017 scan_addr  in  AW  display fetch address.
REQ-018 scan_data  out  DW  last fetched display word; scan_valid  out  1  one-cycle pulse on update.
REQ-019 busy  out  1  high while fill runs.
REQ-020 SRAM_ADDR out AW; SRAM_CE out 1 (constant 0); SRAM_OEN out 1; SRAM_WEN out 1; SRAM_DQ inout DW.

Function
REQ-021 States: FILL_WR, FILL_HOLD, IDLE, SCAN, RD, MERGE, WR, HOLD, ACK.
REQ-022 Fill: FILL_WR (WEN=0, DQ=INIT_WORD, addr INIT_BASE+n) then FILL_HOLD (WEN=1, DQ still driven), n=0..INIT_LEN-1, then IDLE; busy=1 throughout; ch_stb and scan_req ignored, no acks.
REQ-023 Arbitration only in IDLE: scan_req wins, except when last served op was a scan and any ch_stb high, then channel wins.
REQ-024 Channel choice round-robin from (last+1) mod NCH; last updates on each channel grant.
REQ-025 Grant latches winner's addr, we, din, lane; input changes ignored until ACK.
REQ-026 SCAN: SRAM_ADDR = latched scan_addr, OEN=0; SRAM_DQ captured into scan_data at exit edge; scan_valid high in following cycle; -> IDLE.
REQ-027 Read: RD (OEN=0, capture into ch_dout[i]) -> ACK; ack in 2nd cycle after grant edge.
REQ-028 Write, lane all ones: WR (WEN=0, DQ driven) -> HOLD (WEN=1, DQ and addr held) -> ACK; ack in 3rd cycle.
REQ-029 Write, partial lanes: RD -> MERGE (enabled lanes from din, others from read word) -> WR -> HOLD -> ACK; ack in 5th cycle; ch_dout unchanged.
REQ-030 Write, lane all zero: direct ACK in 1st cycle, no SRAM cycle.
REQ-031 ACK: ch_ack[i]=1 one cycle -> IDLE; requester drops stb at that edge.
REQ-032 OEN=0 only in SCAN/RD; WEN=0 only in WR/FILL_WR; DQ driven only in WR, HOLD, FILL_WR, FILL_HOLD, else high-Z; OEN=0 never coincides with driven DQ.
REQ-033 Address arithmetic modulo 2^AW.

Reset
REQ-034 rst=1: ch_ack=0, ch_dout=0, scan_data=0, scan_valid=0, SRAM_ADDR=0, WEN=1, OEN=1, DQ high-Z, last=NCH-1, last-op=channel; state FILL_WR with n=0 and busy=1 if INIT_LEN>0, else IDLE with busy=0.
REQ-035 Reset mid-operation abandons transaction, no ack issued; fill restarts at INIT_BASE.

Verification
REQ-036 Reset, INIT_LEN=128 -> 128 writes of 48'h000008080000 to 0x80000..0x8007F, busy drops after 256 cycles, no acks meanwhile.
REQ-037 ch0 write 48'h111122223333 lane 3'b111 to 0x10, then read -> write ack cycle 3, read ack cycle 2, ch_dout0 = 48'h111122223333.
REQ-038 Word 48'hAAAABBBBCCCC, ch1 write 48'h000000001234 lane 3'b001 -> memory 48'hAAAABBBB1234, ack cycle 5.
REQ-039 ch0 and ch1 both streaming reads -> grants alternate 0,1,0,1; first grant ch0.
REQ-040 scan_req held high with ch0 requesting -> scan and ch0 alternate; scan_valid pulses with correct data.
REQ-041 rst asserted in WR -> WEN=1 and DQ high-Z next cycle, no ack, fill restarts at 0x80000.

Source files
------------

// File: rtl/sram_arbiter.sv
// Shares one asynchronous SRAM among NCH request channels and a display scan port.
// After reset a region is preset with INIT_WORD before any requester is served.
module sram_arbiter #(
  parameter int              NCH       = 2,
  parameter int              AW        = 20,
  parameter int              DW        = 48,
  parameter logic [AW-1:0]   INIT_BASE = 20'h80000,
  parameter int              INIT_LEN  = 128,
  parameter logic [DW-1:0]   INIT_WORD = 48'h000008080000
) (
  input  logic                clk_50mhz,
  input  logic                rst,
  input  logic [NCH-1:0]      ch_stb,
  input  logic [NCH-1:0]      ch_we,
  input  logic [NCH*AW-1:0]   ch_addr,
  input  logic [NCH*DW-1:0]   ch_din,
  input  logic [NCH*DW/16-1:0] ch_lane,
  output logic [NCH*DW-1:0]   ch_dout,
  output logic [NCH-1:0]      ch_ack,
  input  logic                scan_req,
  input  logic [AW-1:0]       scan_addr,
  output logic [DW-1:0]       scan_data,
  output logic                scan_valid,
  output logic                busy,
  output logic [AW-1:0]       SRAM_ADDR,
  output logic                SRAM_CE,
  output logic                SRAM_OEN,
  output logic                SRAM_WEN,
  inout  wire  [DW-1:0]       SRAM_DQ
);

  localparam int NL = DW / 16;
  localparam int IW = $clog2(NCH);
  localparam int CW = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1;

  typedef enum logic [3:0] {
    FILL_WR, FILL_HOLD, IDLE, SCAN, RD, MERGE, WR, HOLD, ACK
  } state_t;

  state_t          state;
  logic [CW-1:0]   fill_cnt;
  logic [AW-1:0]   addr_q;
  logic            we_q;
  logic [DW-1:0]   din_q;
  logic [NL-1:0]   lane_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   rdw_q;
  logic [IW-1:0]   sel_q;
  logic [IW-1:0]   last_q;
  logic            last_scan_q;
  logic            rr_hit;
  logic [IW-1:0]   rr_idx;
  int              cand;

  function automatic logic [DW-1:0] merge_lanes(input logic [DW-1:0] wr,
                                                input logic [DW-1:0] rd,
                                                input logic [NL-1:0] lane);
    for (int k = 0; k < NL; k++)
      merge_lanes[16*k +: 16] = lane[k] ? wr[16*k +: 16] : rd[16*k +: 16];
  endfunction

  function automatic logic [NCH-1:0] onehot(input logic [IW-1:0] idx);
    onehot = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Round-robin: scan from last+NCH down to last+1 so the nearest successor wins.
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = '0;
    cand   = 0;
    for (int k = NCH; k >= 1; k--) begin
      cand = (int'(last_q) + k) % NCH;
      if (ch_stb[cand]) begin
        rr_hit = 1'b1;
        rr_idx = IW'(cand);
      end
    end
  end

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      state       <= (INIT_LEN > 0) ? FILL_WR : IDLE;
      fill_cnt    <= '0;
      addr_q      <= INIT_BASE;
      ch_ack      <= '0;
      ch_dout     <= '0;
      scan_data   <= '0;
      scan_valid  <= 1'b0;
      last_q      <= IW'(NCH - 1);
      last_scan_q <= 1'b0;
    end else begin
      ch_ack     <= '0;
      scan_valid <= 1'b0;
      case (state)
        FILL_WR: state <= FILL_HOLD;
        FILL_HOLD: begin
          if (fill_cnt == CW'(INIT_LEN - 1)) begin
            state <= IDLE;
          end else begin
            fill_cnt <= fill_cnt + 1'b1;
            addr_q   <= addr_q + 1'b1;
            state    <= FILL_WR;
          end
        end
        IDLE: begin
          if (scan_req && !(last_scan_q && |ch_stb)) begin
            addr_q      <= scan_addr;
            last_scan_q <= 1'b1;
            state       <= SCAN;
          end else if (rr_hit) begin
            sel_q       <= rr_idx;
            last_q      <= rr_idx;
            last_scan_q <= 1'b0;
            addr_q      <= ch_addr[rr_idx*AW +: AW];
            we_q        <= ch_we[rr_idx];
            din_q       <= ch_din[rr_idx*DW +: DW];
            wdata_q     <= ch_din[rr_idx*DW +: DW];
            lane_q      <= ch_lane[rr_idx*NL +: NL];
            if (!ch_we[rr_idx]) begin
              state <= RD;
            end else if (&ch_lane[rr_idx*NL +: NL]) begin
              state <= WR;
            end else if (ch_lane[rr_idx*NL +: NL] == '0) begin
              ch_ack <= onehot(rr_idx);
              state  <= ACK;
            end else begin
              state <= RD;
            end
          end
        end
        SCAN: begin
          scan_data  <= SRAM_DQ;
          scan_valid <= 1'b1;
          state      <= IDLE;
        end
        // A read here either completes a channel read or feeds a lane merge.
        RD: begin
          if (we_q) begin
            rdw_q <= SRAM_DQ;
            state <= MERGE;
          end else begin
            ch_dout[sel_q*DW +: DW] <= SRAM_DQ;
            ch_ack <= onehot(sel_q);
            state  <= ACK;
          end
        end
        MERGE: begin
          wdata_q <= merge_lanes(din_q, rdw_q, lane_q);
          state   <= WR;
        end
        WR:   state <= HOLD;
        HOLD: begin
          ch_ack <= onehot(sel_q);
          state  <= ACK;
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode the state register; reset forces the bus quiet immediately.
  logic fill_st;
  logic dq_drive;
  assign fill_st   = (state == FILL_WR) || (state == FILL_HOLD);
  assign busy      = fill_st;
  assign dq_drive  = !rst && (fill_st || state == WR || state == HOLD);
  assign SRAM_CE   = 1'b0;
  assign SRAM_WEN  = rst || !((state == FILL_WR) || (state == WR));
  assign SRAM_OEN  = rst || !((state == SCAN) || (state == RD));
  assign SRAM_ADDR = rst ? '0 : addr_q;
  assign SRAM_DQ   = dq_drive ? (fill_st ? INIT_WORD : wdata_q) : {DW{1'bz}};

endmodule
